// File: rtl/queen_solver_ctrl_if.sv
// ---------------------------------------------------------------------------------------------
// queen_solver_ctrl_if
//   Host-side bundle of the N-queens solver controller: start/abort control, busy/done status
//   and the valid/ready solution port.
//
//   Signals
//     start      host -> solver  begin a search (sampled only while idle)
//     abort      host -> solver  abandon the current search
//     sol_ready  host -> solver  consumer accepts the presented board
//     busy       solver -> host  search in progress
//     done       solver -> host  one-cycle pulse when the search ends normally
//     sol_valid  solver -> host  sol_board holds a complete placement
//     sol_board  solver -> host  column of row r at [3r+2:3r], unused rows read 0
//     sol_count  solver -> host  solutions accepted since the last start, saturating
//
//   Modports
//     master  host / testbench side
//     slave   solver side
// ---------------------------------------------------------------------------------------------
interface queen_solver_ctrl_if;

    logic        start;
    logic        abort;
    logic        sol_ready;
    logic        busy;
    logic        done;
    logic        sol_valid;
    logic [23:0] sol_board;
    logic [6:0]  sol_count;

    modport master (
        output start,
        output abort,
        output sol_ready,
        input  busy,
        input  done,
        input  sol_valid,
        input  sol_board,
        input  sol_count
    );

    modport slave (
        input  start,
        input  abort,
        input  sol_ready,
        output busy,
        output done,
        output sol_valid,
        output sol_board,
        output sol_count
    );

endinterface

// File: rtl/queen_solver_ctrl.sv
// ---------------------------------------------------------------------------------------------
// queen_solver_ctrl
//   Backtracking N-queens solver controller. One pairwise is_safe comparison is evaluated per
//   cycle between the candidate (row, col) and one already-placed queen. Every complete
//   placement is presented on a valid/ready solution port; boards appear in lexicographic
//   order with row 0 most significant.
//
//   Parameters
//     N         board size, 4..8 (3-bit coordinates)
//     FIND_ALL  1: enumerate every solution, 0: finish once the first solution is accepted
//
//   Ports
//     clk    clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    queen_solver_ctrl_if.slave (start, abort, busy, done, sol_valid, sol_ready,
//            sol_board, sol_count)
// ---------------------------------------------------------------------------------------------
module queen_solver_ctrl #(
    parameter int unsigned N        = 8,
    parameter bit          FIND_ALL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    queen_solver_ctrl_if.slave bus
);

    localparam logic [2:0] LastIdx = 3'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StNext,
        StBacktrack,
        StEmit,
        StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      row_q, row_d;
    logic [2:0]      col_q, col_d;
    logic [2:0]      chk_q, chk_d;
    // Eight slots regardless of N: rows >= N are never written, so they stay 0 on the board.
    logic [7:0][2:0] pos_q, pos_d;
    logic [23:0]     board_q, board_d;
    logic [6:0]      count_q, count_d;

    // Pairwise is_safe datapath: candidate (row_q, col_q) against placed queen (chk_q, pos[chk_q]).
    logic [2:0] placed_col;
    logic [2:0] col_dist;
    logic [2:0] row_dist;
    logic       safe;
    logic       last_chk;

    always_comb begin
        placed_col = pos_q[chk_q];
        col_dist   = (col_q > placed_col) ? (col_q - placed_col) : (placed_col - col_q);
        row_dist   = row_q - chk_q;
        // Row 0 has nothing to conflict with.
        safe       = (row_q == 3'd0) ||
                     ((placed_col != col_q) && (col_dist != row_dist));
        last_chk   = (row_q == 3'd0) || (chk_q == row_q - 3'd1);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        chk_d   = chk_q;
        pos_d   = pos_q;
        board_d = board_q;
        count_d = count_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    row_d   = 3'd0;
                    col_d   = 3'd0;
                    chk_d   = 3'd0;
                    count_d = 7'd0;
                    state_d = StCheck;
                end
            end

            StCheck: begin
                if (!safe) begin
                    state_d = StNext;
                end else if (!last_chk) begin
                    chk_d = chk_q + 3'd1;
                end else begin
                    pos_d[row_q] = col_q;
                    if (row_q == LastIdx) begin
                        board_d = pos_d;
                        state_d = StEmit;
                    end else begin
                        row_d = row_q + 3'd1;
                        col_d = 3'd0;
                        chk_d = 3'd0;
                    end
                end
            end

            StNext: begin
                if (col_q != LastIdx) begin
                    col_d   = col_q + 3'd1;
                    chk_d   = 3'd0;
                    state_d = StCheck;
                end else begin
                    state_d = StBacktrack;
                end
            end

            StBacktrack: begin
                if (row_q == 3'd0) begin
                    state_d = StFinish;
                end else begin
                    // Resume the previous row from the column it was holding.
                    row_d   = row_q - 3'd1;
                    col_d   = pos_q[row_q - 3'd1];
                    state_d = StNext;
                end
            end

            StEmit: begin
                if (bus.sol_ready) begin
                    if (count_q != 7'h7f) begin
                        count_d = count_q + 7'd1;
                    end
                    // col_q still equals pos[N-1], so NEXT continues the enumeration from there.
                    state_d = FIND_ALL ? StNext : StFinish;
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including a handshake in the same cycle.
        if (bus.abort) begin
            state_d = StIdle;
            count_d = count_q;
            board_d = board_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            chk_q   <= 3'd0;
            pos_q   <= '0;
            board_q <= '0;
            count_q <= 7'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            chk_q   <= chk_d;
            pos_q   <= pos_d;
            board_q <= board_d;
            count_q <= count_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        bus.busy      = (state_q != StIdle) && (state_q != StFinish);
        bus.done      = (state_q == StFinish);
        bus.sol_valid = (state_q == StEmit);
        bus.sol_board = board_q;
        bus.sol_count = count_q;
    end

endmodule

// File: tb/tb_queen_solver_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_queen_solver_ctrl
//   Bench for queen_solver_ctrl. Three instances: N=8 enumerate-all (main target, checked every
//   cycle against a permutation-based reference list), N=4 enumerate-all and N=8 first-only.
// ---------------------------------------------------------------------------------------------
module tb_queen_solver_ctrl;

    typedef logic [23:0] board_q_t[$];

    logic clk = 1'b0;
    logic rst8_n, rst4_n, rstf_n;

    always #5 clk = ~clk;

    queen_solver_ctrl_if bus8();
    queen_solver_ctrl_if bus4();
    queen_solver_ctrl_if busf();

    queen_solver_ctrl #(.N(8), .FIND_ALL(1'b1)) u_dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));
    queen_solver_ctrl #(.N(4), .FIND_ALL(1'b1)) u_dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));
    queen_solver_ctrl #(.N(8), .FIND_ALL(1'b0)) u_dutf (.clk(clk), .rst_n(rstf_n), .bus(busf));

    int       n_checks;
    int       n_errors;
    bit       mon_on;
    board_q_t exp8;
    board_q_t exp4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: walk every permutation of columns in lexicographic order and keep those with
    // no shared diagonal. Permutations already exclude shared rows and columns.
    function automatic board_q_t gen_solutions(input int n);
        board_q_t    sols;
        int          p[8];
        int          i, j, t, a, b;
        bit          more, ok;
        logic [23:0] w;
        for (int x = 0; x < 8; x++) p[x] = x;
        more = 1'b1;
        while (more) begin
            ok = 1'b1;
            for (int r1 = 0; r1 < n; r1++) begin
                for (int r2 = r1 + 1; r2 < n; r2++) begin
                    if ((r2 - r1 == p[r2] - p[r1]) || (r2 - r1 == p[r1] - p[r2])) ok = 1'b0;
                end
            end
            if (ok) begin
                w = '0;
                for (int r = 0; r < n; r++) w[3*r +: 3] = 3'(p[r]);
                sols.push_back(w);
            end
            i = n - 2;
            while (i >= 0 && p[i] >= p[i+1]) i--;
            if (i < 0) begin
                more = 1'b0;
            end else begin
                j = n - 1;
                while (p[j] <= p[i]) j--;
                t = p[i]; p[i] = p[j]; p[j] = t;
                a = i + 1;
                b = n - 1;
                while (a < b) begin
                    t = p[a]; p[a] = p[b]; p[b] = t;
                    a++;
                    b--;
                end
            end
        end
        return sols;
    endfunction

    // Per-cycle compare for the N=8 enumerate-all instance. Outputs are checked at the falling
    // edge, then the model absorbs the inputs that the next rising edge will sample.
    int          m_count;
    int          m_idx;
    bit          m_hold;
    bit          m_post_reset;
    bit          m_post_abort;
    bit          m_post_start;
    logic [23:0] m_board;

    initial begin
        m_count = 0; m_idx = 0; m_hold = 0;
        m_post_reset = 0; m_post_abort = 0; m_post_start = 0; m_board = '0;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("count_track", bus8.sol_count, m_count);
            check("busy_done_excl", bus8.busy & bus8.done, 1'b0);
            if (m_hold) begin
                check("hold_valid", bus8.sol_valid, 1'b1);
                check("hold_board", bus8.sol_board, m_board);
            end
            if (m_post_reset) begin
                check("reset_busy", bus8.busy, 1'b0);
                check("reset_valid", bus8.sol_valid, 1'b0);
                check("reset_board", bus8.sol_board, 24'h0);
                check("reset_done", bus8.done, 1'b0);
            end
            if (m_post_abort) begin
                check("abort_busy", bus8.busy, 1'b0);
                check("abort_valid", bus8.sol_valid, 1'b0);
                check("abort_done", bus8.done, 1'b0);
            end
            if (m_post_start) check("start_busy", bus8.busy, 1'b1);
            if (bus8.sol_valid) begin
                if (m_idx < exp8.size()) check("board_seq", bus8.sol_board, exp8[m_idx]);
                else check("board_overrun", m_idx, exp8.size());
            end
            if (bus8.done) check("done_after_all", m_idx, exp8.size());

            m_hold = 0; m_post_reset = 0; m_post_abort = 0; m_post_start = 0;
            if (!rst8_n) begin
                m_count = 0;
                m_idx = 0;
                m_post_reset = 1;
            end else if (bus8.abort) begin
                m_post_abort = 1;
            end else if (bus8.start && !bus8.busy && !bus8.done) begin
                m_count = 0;
                m_idx = 0;
                m_post_start = 1;
            end else if (bus8.sol_valid && bus8.sol_ready) begin
                if (m_count < 127) m_count++;
                m_idx++;
            end else if (bus8.sol_valid) begin
                m_hold = 1;
                m_board = bus8.sol_board;
            end
        end
    end

    bit ok;
    int got;

    initial begin
        n_checks = 0; n_errors = 0; mon_on = 0;
        rst8_n = 0; rst4_n = 0; rstf_n = 0;
        bus8.start = 0; bus8.abort = 0; bus8.sol_ready = 0;
        bus4.start = 0; bus4.abort = 0; bus4.sol_ready = 0;
        busf.start = 0; busf.abort = 0; busf.sol_ready = 0;

        // Pin the reference model with hand-derived boards.
        exp8 = gen_solutions(8);
        exp4 = gen_solutions(4);
        check("model_n8_count", exp8.size(), 92);
        check("model_n8_first", exp8[0], 24'h672BE0);
        check("model_n4_count", exp4.size(), 2);
        check("model_n4_first", exp4[0], 24'h000419);
        check("model_n4_second", exp4[1], 24'h0002C2);

        tick(2);
        check("rst_busy", bus8.busy, 1'b0);
        check("rst_done", bus8.done, 1'b0);
        check("rst_valid", bus8.sol_valid, 1'b0);
        check("rst_board", bus8.sol_board, 24'h0);
        check("rst_count", bus8.sol_count, 7'd0);
        rst8_n = 1; rst4_n = 1; rstf_n = 1;
        mon_on = 1;

        // N=4, enumerate all.
        bus4.sol_ready = 1; bus4.start = 1;
        tick(1);
        bus4.start = 0;
        check("n4_busy", bus4.busy, 1'b1);
        got = 0; ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (bus4.sol_valid) begin
                if (got < 2) check($sformatf("n4_board%0d", got), bus4.sol_board, exp4[got]);
                got++;
            end
            if (bus4.done) ok = 1;
            else tick(1);
        end
        check("n4_done", ok, 1'b1);
        check("n4_solutions", got, 2);
        check("n4_count", bus4.sol_count, 7'd2);
        check("n4_done_busy", bus4.busy, 1'b0);

        // N=8, first solution only.
        busf.sol_ready = 1; busf.start = 1;
        tick(1);
        busf.start = 0;
        ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (busf.sol_valid) ok = 1;
            else tick(1);
        end
        check("first_found", ok, 1'b1);
        check("first_board", busf.sol_board, 24'h672BE0);
        tick(1);
        check("first_done", busf.done, 1'b1);
        check("first_count", busf.sol_count, 7'd1);
        check("first_valid_drop", busf.sol_valid, 1'b0);
        check("first_busy", busf.busy, 1'b0);
        tick(1);
        check("first_done_pulse", busf.done, 1'b0);

        // N=8 enumerate all, with back-pressure on the first board.
        bus8.sol_ready = 0; bus8.start = 1;
        tick(1);
        bus8.start = 0;
        ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (bus8.sol_valid) ok = 1;
            else tick(1);
        end
        check("bp_found", ok, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("bp_valid_hold", bus8.sol_valid, 1'b1);
            check("bp_board_hold", bus8.sol_board, 24'h672BE0);
            check("bp_count_hold", bus8.sol_count, 7'd0);
            tick(1);
        end
        bus8.sol_ready = 1;
        tick(1);
        check("bp_count_once", bus8.sol_count, 7'd1);
        // Stray start while busy must not restart the search.
        bus8.start = 1;
        tick(1);
        bus8.start = 0;
        check("busy_start_ignored", bus8.busy, 1'b1);
        check("busy_start_count", bus8.sol_count, 7'd1);
        ok = 0;
        for (int i = 0; i < 150000 && !ok; i++) begin
            if (bus8.done) ok = 1;
            else tick(1);
        end
        check("all_done", ok, 1'b1);
        check("all_count", bus8.sol_count, 7'd92);
        check("all_done_busy", bus8.busy, 1'b0);
        tick(1);
        check("all_done_pulse", bus8.done, 1'b0);
        check("all_count_hold", bus8.sol_count, 7'd92);

        // Abort after three solutions, then re-start.
        bus8.start = 1;
        tick(1);
        bus8.start = 0;
        ok = 0;
        for (int i = 0; i < 40000 && !ok; i++) begin
            if (bus8.sol_count == 7'd3) ok = 1;
            else tick(1);
        end
        check("abort_reach3", ok, 1'b1);
        bus8.abort = 1;
        tick(1);
        bus8.abort = 0;
        check("abort_busy_now", bus8.busy, 1'b0);
        check("abort_count", bus8.sol_count, 7'd3);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_done", bus8.done, 1'b0);
            tick(1);
        end
        bus8.start = 1;
        tick(1);
        bus8.start = 0;
        check("restart_count", bus8.sol_count, 7'd0);
        ok = 0;
        for (int i = 0; i < 40000 && !ok; i++) begin
            if (bus8.sol_count == 7'd5) ok = 1;
            else tick(1);
        end
        check("restart_reach5", ok, 1'b1);

        // Reset while a board is pending.
        bus8.sol_ready = 0;
        ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (bus8.sol_valid) ok = 1;
            else tick(1);
        end
        check("rst_emit_found", ok, 1'b1);
        rst8_n = 0;
        tick(1);
        rst8_n = 1;
        check("midrst_busy", bus8.busy, 1'b0);
        check("midrst_valid", bus8.sol_valid, 1'b0);
        check("midrst_board", bus8.sol_board, 24'h0);
        check("midrst_count", bus8.sol_count, 7'd0);
        tick(1);
        check("midrst_idle", bus8.busy, 1'b0);
        bus8.sol_ready = 1; bus8.start = 1;
        tick(1);
        bus8.start = 0;
        ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (bus8.sol_count == 7'd1) ok = 1;
            else tick(1);
        end
        check("midrst_resume", ok, 1'b1);
        bus8.abort = 1;
        tick(1);
        bus8.abort = 0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
